// File: rtl/butterfly_stage_pkg.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | butterfly_stage_pkg                                                      |
// | Twiddle constants and trivial-twiddle classification for butterfly_stage |
// | Rev 1.0                                                                  |
// +--------------------------------------------------------------------------+
package butterfly_stage_pkg;

  typedef enum logic [1:0] {
    TW_GEN  = 2'd0,
    TW_ONE  = 2'd1,
    TW_NEGJ = 2'd2
  } tw_sel_e;

  localparam real C_PI = 3.14159265358979323846;

  // Q(tw_w-2) representation of 1.0
  function automatic int q_one(input int tw_w);
    return 1 << (tw_w - 2);
  endfunction

  // Round to nearest, ties away from zero, so +/- angles stay symmetric
  function automatic int rnd_sym(input real v);
    if (v >= 0.0) return $rtoi(v + 0.5);
    else          return -$rtoi(-v + 0.5);
  endfunction

  function automatic int tw_re(input int k, input int m, input int tw_w);
    return rnd_sym($cos(2.0 * C_PI * real'(k) / real'(m)) * real'(q_one(tw_w)));
  endfunction

  function automatic int tw_im(input int k, input int m, input int tw_w);
    return rnd_sym(-$sin(2.0 * C_PI * real'(k) / real'(m)) * real'(q_one(tw_w)));
  endfunction

  // k/(2h) == 0 gives W=1, k/(2h) == 1/4 gives W=-j
  function automatic tw_sel_e tw_class(input int k, input int h);
    if (k == 0)          return TW_ONE;
    else if (2 * k == h) return TW_NEGJ;
    else                 return TW_GEN;
  endfunction

  function automatic bit is_pow2(input int v);
    return (v > 0) && ((v & (v - 1)) == 0);
  endfunction

endpackage
`default_nettype wire

// File: rtl/butterfly_stage_bf2_core.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | bf2_core                                                                 |
// | One radix-2 complex butterfly, two register stages, saturation flag      |
// | Rev 1.0                                                                  |
// +--------------------------------------------------------------------------+
module bf2_core
  import butterfly_stage_pkg::*;
#(
  parameter int      DATA_W = 16,
  parameter int      TW_W   = 16,
  parameter int      SCALE  = 0,
  parameter int      TW_RE  = 1 << (TW_W - 2),
  parameter int      TW_IM  = 0,
  parameter tw_sel_e TW_SEL = TW_ONE
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     en1_i,
  input  logic                     en2_i,
  input  logic                     inv_i,
  input  logic signed [DATA_W-1:0] a_re_i,
  input  logic signed [DATA_W-1:0] a_im_i,
  input  logic signed [DATA_W-1:0] b_re_i,
  input  logic signed [DATA_W-1:0] b_im_i,
  output logic signed [DATA_W-1:0] y0_re_o,
  output logic signed [DATA_W-1:0] y0_im_o,
  output logic signed [DATA_W-1:0] y1_re_o,
  output logic signed [DATA_W-1:0] y1_im_o,
  output logic                     sat_o
);

  localparam int TWD = DATA_W + 1;
  localparam int SW  = DATA_W + 2;
  localparam logic signed [SW-1:0] C_MAX = {3'b000, {(DATA_W-1){1'b1}}};
  localparam logic signed [SW-1:0] C_MIN = {3'b111, {(DATA_W-1){1'b0}}};

  logic signed [TWD-1:0] w_t_re;
  logic signed [TWD-1:0] w_t_im;

  generate
    if (TW_SEL == TW_ONE) begin : g_tw_one
      logic w_inv_unused;
      assign w_inv_unused = inv_i;
      assign w_t_re = TWD'(b_re_i);
      assign w_t_im = TWD'(b_im_i);
    end else if (TW_SEL == TW_NEGJ) begin : g_tw_negj
      // -j maps (re,im) to (im,-re); its conjugate +j maps to (-im,re)
      assign w_t_re = inv_i ? -TWD'(b_im_i) : TWD'(b_im_i);
      assign w_t_im = inv_i ? TWD'(b_re_i) : -TWD'(b_re_i);
    end else begin : g_tw_gen
      localparam int PW = DATA_W + TW_W + 1;
      localparam logic signed [TW_W-1:0] C_WR   = TW_W'(TW_RE);
      localparam logic signed [TW_W-1:0] C_WI   = TW_W'(TW_IM);
      localparam logic signed [PW-1:0]   C_HALF = PW'(1) <<< (TW_W - 3);

      logic signed [TW_W-1:0] w_wi;
      logic signed [PW-1:0]   w_pr;
      logic signed [PW-1:0]   w_pi;

      assign w_wi   = inv_i ? -C_WI : C_WI;
      assign w_pr   = PW'(b_re_i) * PW'(C_WR) - PW'(b_im_i) * PW'(w_wi);
      assign w_pi   = PW'(b_re_i) * PW'(w_wi) + PW'(b_im_i) * PW'(C_WR);
      assign w_t_re = TWD'((w_pr + C_HALF) >>> (TW_W - 2));
      assign w_t_im = TWD'((w_pi + C_HALF) >>> (TW_W - 2));
    end
  endgenerate

  logic signed [DATA_W-1:0] a_re_q;
  logic signed [DATA_W-1:0] a_im_q;
  logic signed [TWD-1:0]    t_re_q;
  logic signed [TWD-1:0]    t_im_q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      a_re_q <= '0;
      a_im_q <= '0;
      t_re_q <= '0;
      t_im_q <= '0;
    end else if (en1_i) begin
      a_re_q <= a_re_i;
      a_im_q <= a_im_i;
      t_re_q <= w_t_re;
      t_im_q <= w_t_im;
    end
  end

  // Result packs {saturated, value}
  function automatic logic [DATA_W:0] fit(input logic signed [SW-1:0] s);
    logic signed [SW-1:0] v;
    v = (SCALE != 0) ? (s >>> 1) : s;
    if (v > C_MAX)      return {1'b1, DATA_W'(C_MAX)};
    else if (v < C_MIN) return {1'b1, DATA_W'(C_MIN)};
    else                return {1'b0, DATA_W'(v)};
  endfunction

  logic signed [SW-1:0] w_s0_re;
  logic signed [SW-1:0] w_s0_im;
  logic signed [SW-1:0] w_s1_re;
  logic signed [SW-1:0] w_s1_im;
  logic [DATA_W:0]      w_f0_re;
  logic [DATA_W:0]      w_f0_im;
  logic [DATA_W:0]      w_f1_re;
  logic [DATA_W:0]      w_f1_im;

  assign w_s0_re = SW'(a_re_q) + SW'(t_re_q);
  assign w_s0_im = SW'(a_im_q) + SW'(t_im_q);
  assign w_s1_re = SW'(a_re_q) - SW'(t_re_q);
  assign w_s1_im = SW'(a_im_q) - SW'(t_im_q);

  assign w_f0_re = fit(w_s0_re);
  assign w_f0_im = fit(w_s0_im);
  assign w_f1_re = fit(w_s1_re);
  assign w_f1_im = fit(w_s1_im);

  logic signed [DATA_W-1:0] y0_re_q;
  logic signed [DATA_W-1:0] y0_im_q;
  logic signed [DATA_W-1:0] y1_re_q;
  logic signed [DATA_W-1:0] y1_im_q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      y0_re_q <= '0;
      y0_im_q <= '0;
      y1_re_q <= '0;
      y1_im_q <= '0;
    end else if (en2_i) begin
      y0_re_q <= w_f0_re[DATA_W-1:0];
      y0_im_q <= w_f0_im[DATA_W-1:0];
      y1_re_q <= w_f1_re[DATA_W-1:0];
      y1_im_q <= w_f1_im[DATA_W-1:0];
    end
  end

  assign sat_o   = en2_i & (w_f0_re[DATA_W] | w_f0_im[DATA_W] |
                            w_f1_re[DATA_W] | w_f1_im[DATA_W]);
  assign y0_re_o = y0_re_q;
  assign y0_im_o = y0_im_q;
  assign y1_re_o = y1_re_q;
  assign y1_im_o = y1_im_q;

endmodule
`default_nettype wire

// File: rtl/butterfly_stage.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | butterfly_stage                                                          |
// | Pipelined radix-2 DIT FFT/IFFT stage: N/2 butterflies, valid, ovf flag  |
// | Rev 1.0                                                                  |
// +--------------------------------------------------------------------------+
module butterfly_stage
  import butterfly_stage_pkg::*;
#(
  parameter int DATA_W = 16,
  parameter int N      = 8,
  parameter int STAGE  = 1,
  parameter int TW_W   = 16,
  parameter int SCALE  = 0
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  in_ready,
  input  logic                  inverse,
  input  logic [N*DATA_W-1:0]   din_real,
  input  logic [N*DATA_W-1:0]   din_imag,
  output logic [N*DATA_W-1:0]   dout_real,
  output logic [N*DATA_W-1:0]   dout_imag,
  output logic                  out_ready,
  output logic                  ovf,
  input  logic                  ovf_clr
);

  localparam int H  = 1 << STAGE;
  localparam int NB = N / 2;

  logic          valid1_q;
  logic          valid2_q;
  logic          ovf_q;
  logic          ovf_d;
  logic [NB-1:0] w_sat;

  generate
    if (!is_pow2(N) || N < 4 || N > 64 || STAGE < 0 || STAGE >= $clog2(N)) begin : g_bad_param
      $error("butterfly_stage: N must be a power of two in 4..64 and STAGE in 0..log2(N)-1");
    end else begin : g_ok
      for (genvar p = 0; p < NB; p++) begin : g_bf
        localparam int K  = p % H;
        localparam int IA = (p / H) * 2 * H + K;
        localparam int IB = IA + H;

        bf2_core #(
          .DATA_W (DATA_W),
          .TW_W   (TW_W),
          .SCALE  (SCALE),
          .TW_RE  (tw_re(K, 2 * H, TW_W)),
          .TW_IM  (tw_im(K, 2 * H, TW_W)),
          .TW_SEL (tw_class(K, H))
        ) u_core (
          .clk     (clk),
          .rst     (rst),
          .en1_i   (in_ready),
          .en2_i   (valid1_q),
          .inv_i   (inverse),
          .a_re_i  (din_real[IA*DATA_W +: DATA_W]),
          .a_im_i  (din_imag[IA*DATA_W +: DATA_W]),
          .b_re_i  (din_real[IB*DATA_W +: DATA_W]),
          .b_im_i  (din_imag[IB*DATA_W +: DATA_W]),
          .y0_re_o (dout_real[IA*DATA_W +: DATA_W]),
          .y0_im_o (dout_imag[IA*DATA_W +: DATA_W]),
          .y1_re_o (dout_real[IB*DATA_W +: DATA_W]),
          .y1_im_o (dout_imag[IB*DATA_W +: DATA_W]),
          .sat_o   (w_sat[p])
        );
      end
    end
  endgenerate

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      valid1_q <= 1'b0;
      valid2_q <= 1'b0;
    end else begin
      valid1_q <= in_ready;
      valid2_q <= valid1_q;
    end
  end

  // A fresh saturation outranks a same-cycle clear
  always_comb begin
    ovf_d = ovf_q;
    if (ovf_clr) ovf_d = 1'b0;
    if (|w_sat)  ovf_d = 1'b1;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) ovf_q <= 1'b0;
    else     ovf_q <= ovf_d;
  end

  assign out_ready = valid2_q;
  assign ovf       = ovf_q;

endmodule
`default_nettype wire

// File: tb/tb_butterfly_stage.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | tb_butterfly_stage                                                       |
// | Directed self-checking bench for butterfly_stage (N=8, several STAGEs)  |
// | Rev 1.0                                                                  |
// +--------------------------------------------------------------------------+
module tb_butterfly_stage;

  logic         clk = 1'b0;
  logic         rst;
  logic         in_ready;
  logic         inverse;
  logic         ovf_clr;
  logic [127:0] din_re;
  logic [127:0] din_im;

  logic [127:0] d1_re, d1_im, d2_re, d2_im, d0_re, d0_im, dh_re, dh_im;
  logic         rdy1, rdy2, rdy0, rdyh;
  logic         ovf1, ovf2, ovf0, ovfh;

  int n_cmp  = 0;
  int n_fail = 0;

  always #5 clk = ~clk;

  butterfly_stage #(.DATA_W(16), .N(8), .STAGE(1), .TW_W(16), .SCALE(0)) u_s1 (
    .clk(clk), .rst(rst), .in_ready(in_ready), .inverse(inverse),
    .din_real(din_re), .din_imag(din_im), .dout_real(d1_re), .dout_imag(d1_im),
    .out_ready(rdy1), .ovf(ovf1), .ovf_clr(ovf_clr));

  butterfly_stage #(.DATA_W(16), .N(8), .STAGE(2), .TW_W(16), .SCALE(0)) u_s2 (
    .clk(clk), .rst(rst), .in_ready(in_ready), .inverse(inverse),
    .din_real(din_re), .din_imag(din_im), .dout_real(d2_re), .dout_imag(d2_im),
    .out_ready(rdy2), .ovf(ovf2), .ovf_clr(ovf_clr));

  butterfly_stage #(.DATA_W(16), .N(8), .STAGE(0), .TW_W(16), .SCALE(0)) u_s0 (
    .clk(clk), .rst(rst), .in_ready(in_ready), .inverse(inverse),
    .din_real(din_re), .din_imag(din_im), .dout_real(d0_re), .dout_imag(d0_im),
    .out_ready(rdy0), .ovf(ovf0), .ovf_clr(ovf_clr));

  butterfly_stage #(.DATA_W(16), .N(8), .STAGE(0), .TW_W(16), .SCALE(1)) u_h0 (
    .clk(clk), .rst(rst), .in_ready(in_ready), .inverse(inverse),
    .din_real(din_re), .din_imag(din_im), .dout_real(dh_re), .dout_imag(dh_im),
    .out_ready(rdyh), .ovf(ovfh), .ovf_clr(ovf_clr));

  function automatic int el(input logic [127:0] bus, input int i);
    logic signed [15:0] v;
    v = bus[i*16 +: 16];
    return int'(v);
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic set_vec(input int re[8], input int im[8], input logic inv);
    for (int i = 0; i < 8; i++) begin
      din_re[i*16 +: 16] = 16'(re[i]);
      din_im[i*16 +: 16] = 16'(im[i]);
    end
    inverse  = inv;
    in_ready = 1'b1;
  endtask

  task automatic idle();
    in_ready = 1'b0;
    inverse  = 1'b0;
    din_re   = '0;
    din_im   = '0;
  endtask

  task automatic test_reset();
    tick();
    n_cmp++; if (rdy1 !== 1'b0) begin n_fail++; $display("FAIL reset out_ready: got %b expected 0", rdy1); end
    n_cmp++; if (d1_re !== '0 || d1_im !== '0) begin n_fail++; $display("FAIL reset dout: got %h/%h expected 0", d1_re, d1_im); end
    n_cmp++; if (ovf0 !== 1'b0) begin n_fail++; $display("FAIL reset ovf: got %b expected 0", ovf0); end
    rst = 1'b0;
    tick();
    n_cmp++; if (rdy1 !== 1'b0) begin n_fail++; $display("FAIL post-reset out_ready: got %b expected 0", rdy1); end
  endtask

  task automatic run_ramp(input logic inv, input int exp_re[8], input int exp_im[8], input string tag);
    int re[8];
    int im[8];
    for (int i = 0; i < 8; i++) begin re[i] = 100 * (i + 1); im[i] = 0; end
    set_vec(re, im, inv);
    tick();
    idle();
    n_cmp++; if (rdy1 !== 1'b0) begin n_fail++; $display("FAIL %s latency1 out_ready: got %b expected 0", tag, rdy1); end
    tick();
    n_cmp++; if (rdy1 !== 1'b1) begin n_fail++; $display("FAIL %s latency2 out_ready: got %b expected 1", tag, rdy1); end
    for (int i = 0; i < 8; i++) begin
      n_cmp++; if (el(d1_re, i) !== exp_re[i]) begin n_fail++; $display("FAIL %s y%0d re: got %0d expected %0d", tag, i, el(d1_re, i), exp_re[i]); end
      n_cmp++; if (el(d1_im, i) !== exp_im[i]) begin n_fail++; $display("FAIL %s y%0d im: got %0d expected %0d", tag, i, el(d1_im, i), exp_im[i]); end
    end
    tick();
    n_cmp++; if (rdy1 !== 1'b0) begin n_fail++; $display("FAIL %s pulse width out_ready: got %b expected 0", tag, rdy1); end
  endtask

  task automatic test_fixed_stage();
    int er[8] = '{400, 200, -200, 200, 1200, 600, -200, 600};
    int ei[8] = '{0, -400, 0, 400, 0, -800, 0, 800};
    run_ramp(1'b0, er, ei, "fixed");
  endtask

  task automatic test_inverse();
    int er[8] = '{400, 200, -200, 200, 1200, 600, -200, 600};
    int ei[8] = '{0, 400, 0, -400, 0, 800, 0, -800};
    run_ramp(1'b1, er, ei, "inverse");
  endtask

  task automatic test_twiddle();
    int re[8] = '{0, 0, 0, 0, 0, 16384, 0, 0};
    int im[8] = '{0, 0, 0, 0, 0, 0, 0, 0};
    set_vec(re, im, 1'b0);
    tick();
    idle();
    tick();
    n_cmp++; if (rdy2 !== 1'b1) begin n_fail++; $display("FAIL twiddle out_ready: got %b expected 1", rdy2); end
    n_cmp++; if (el(d2_re, 1) !== 11585)  begin n_fail++; $display("FAIL twiddle y1 re: got %0d expected 11585", el(d2_re, 1)); end
    n_cmp++; if (el(d2_im, 1) !== -11585) begin n_fail++; $display("FAIL twiddle y1 im: got %0d expected -11585", el(d2_im, 1)); end
    n_cmp++; if (el(d2_re, 5) !== -11585) begin n_fail++; $display("FAIL twiddle y5 re: got %0d expected -11585", el(d2_re, 5)); end
    n_cmp++; if (el(d2_im, 5) !== 11585)  begin n_fail++; $display("FAIL twiddle y5 im: got %0d expected 11585", el(d2_im, 5)); end
    set_vec(re, im, 1'b1);
    tick();
    idle();
    tick();
    n_cmp++; if (el(d2_re, 1) !== 11585)  begin n_fail++; $display("FAIL twiddle inv y1 re: got %0d expected 11585", el(d2_re, 1)); end
    n_cmp++; if (el(d2_im, 1) !== 11585)  begin n_fail++; $display("FAIL twiddle inv y1 im: got %0d expected 11585", el(d2_im, 1)); end
    n_cmp++; if (el(d2_im, 5) !== -11585) begin n_fail++; $display("FAIL twiddle inv y5 im: got %0d expected -11585", el(d2_im, 5)); end
  endtask

  task automatic test_saturation();
    int re[8] = '{32767, 32767, 0, 0, 0, 0, 0, 0};
    int im[8] = '{-32768, -32768, 0, 0, 0, 0, 0, 0};
    set_vec(re, im, 1'b0);
    tick();
    idle();
    tick();
    n_cmp++; if (el(d0_re, 0) !== 32767)  begin n_fail++; $display("FAIL sat y0 re: got %0d expected 32767", el(d0_re, 0)); end
    n_cmp++; if (el(d0_im, 0) !== -32768) begin n_fail++; $display("FAIL sat y0 im: got %0d expected -32768", el(d0_im, 0)); end
    n_cmp++; if (el(d0_re, 1) !== 0 || el(d0_im, 1) !== 0) begin n_fail++; $display("FAIL sat y1: got (%0d,%0d) expected (0,0)", el(d0_re, 1), el(d0_im, 1)); end
    n_cmp++; if (ovf0 !== 1'b1) begin n_fail++; $display("FAIL sat ovf set: got %b expected 1", ovf0); end
    n_cmp++; if (el(dh_re, 0) !== 32767)  begin n_fail++; $display("FAIL scaled y0 re: got %0d expected 32767", el(dh_re, 0)); end
    n_cmp++; if (el(dh_im, 0) !== -32768) begin n_fail++; $display("FAIL scaled y0 im: got %0d expected -32768", el(dh_im, 0)); end
    n_cmp++; if (el(dh_re, 1) !== 0 || el(dh_im, 1) !== 0) begin n_fail++; $display("FAIL scaled y1: got (%0d,%0d) expected (0,0)", el(dh_re, 1), el(dh_im, 1)); end
    n_cmp++; if (ovfh !== 1'b0) begin n_fail++; $display("FAIL scaled ovf: got %b expected 0", ovfh); end
    tick();
    n_cmp++; if (ovf0 !== 1'b1) begin n_fail++; $display("FAIL sat ovf sticky: got %b expected 1", ovf0); end
    ovf_clr = 1'b1;
    tick();
    ovf_clr = 1'b0;
    n_cmp++; if (ovf0 !== 1'b0) begin n_fail++; $display("FAIL ovf_clr: got %b expected 0", ovf0); end
    set_vec(re, im, 1'b0);
    tick();
    idle();
    ovf_clr = 1'b1;
    tick();
    ovf_clr = 1'b0;
    n_cmp++; if (ovf0 !== 1'b1) begin n_fail++; $display("FAIL set beats clear: got %b expected 1", ovf0); end
    n_cmp++; if (ovfh !== 1'b0) begin n_fail++; $display("FAIL scaled ovf after clr: got %b expected 0", ovfh); end
  endtask

  task automatic test_back_to_back();
    int vld[5] = '{1, 1, 1, 0, 1};
    int av[5]  = '{10, 30, 50, 0, 70};
    int bv[5]  = '{20, 40, 60, 0, 80};
    int iv[5]  = '{0, 1, 0, 0, 1};
    int re[8];
    int im[8];
    int hold_re = 0;
    int hold_im = 0;
    for (int c = 0; c < 7; c++) begin
      if (c < 5 && vld[c] != 0) begin
        for (int i = 0; i < 8; i++) begin re[i] = 0; im[i] = 0; end
        re[1] = av[c];
        re[3] = bv[c];
        set_vec(re, im, iv[c] != 0);
      end else begin
        idle();
      end
      tick();
      if (c >= 1) begin
        logic ev;
        int   e1i;
        int   e3i;
        ev = (c - 1 < 5) ? (vld[c-1] != 0) : 1'b0;
        n_cmp++; if (rdy1 !== ev) begin n_fail++; $display("FAIL b2b cycle%0d out_ready: got %b expected %b", c, rdy1, ev); end
        if (ev) begin
          e1i = (iv[c-1] != 0) ? bv[c-1] : -bv[c-1];
          e3i = -e1i;
          n_cmp++; if (el(d1_re, 1) !== av[c-1] || el(d1_im, 1) !== e1i) begin n_fail++; $display("FAIL b2b cycle%0d y1: got (%0d,%0d) expected (%0d,%0d)", c, el(d1_re, 1), el(d1_im, 1), av[c-1], e1i); end
          n_cmp++; if (el(d1_re, 3) !== av[c-1] || el(d1_im, 3) !== e3i) begin n_fail++; $display("FAIL b2b cycle%0d y3: got (%0d,%0d) expected (%0d,%0d)", c, el(d1_re, 3), el(d1_im, 3), av[c-1], e3i); end
          hold_re = av[c-1];
          hold_im = e1i;
        end else if (c >= 2) begin
          n_cmp++; if (el(d1_re, 1) !== hold_re || el(d1_im, 1) !== hold_im) begin n_fail++; $display("FAIL b2b cycle%0d hold y1: got (%0d,%0d) expected (%0d,%0d)", c, el(d1_re, 1), el(d1_im, 1), hold_re, hold_im); end
        end
      end
    end
  endtask

  task automatic test_reset_midflight();
    int re[8];
    int im[8];
    for (int i = 0; i < 8; i++) begin re[i] = 100 * (i + 1); im[i] = 0; end
    set_vec(re, im, 1'b0);
    tick();
    idle();
    rst = 1'b1;
    #1;
    n_cmp++; if (rdy1 !== 1'b0) begin n_fail++; $display("FAIL midreset out_ready: got %b expected 0", rdy1); end
    n_cmp++; if (d1_re !== '0 || d1_im !== '0) begin n_fail++; $display("FAIL midreset dout: got %h/%h expected 0", d1_re, d1_im); end
    n_cmp++; if (ovf0 !== 1'b0) begin n_fail++; $display("FAIL midreset ovf: got %b expected 0", ovf0); end
    tick();
    rst = 1'b0;
    for (int c = 0; c < 3; c++) begin
      tick();
      n_cmp++; if (rdy1 !== 1'b0) begin n_fail++; $display("FAIL after-release cycle%0d out_ready: got %b expected 0", c, rdy1); end
    end
    set_vec(re, im, 1'b0);
    tick();
    idle();
    tick();
    n_cmp++; if (rdy1 !== 1'b1 || el(d1_re, 0) !== 400) begin n_fail++; $display("FAIL restart: got rdy=%b y0=%0d expected rdy=1 y0=400", rdy1, el(d1_re, 0)); end
  endtask

  initial begin
    rst = 1'b1;
    ovf_clr = 1'b0;
    idle();
    test_reset();
    test_fixed_stage();
    test_inverse();
    test_twiddle();
    test_saturation();
    test_back_to_back();
    test_reset_midflight();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "timeout");
  end

endmodule
`default_nettype wire

// File: doc/butterfly_stage.md
Name: butterfly_stage

Overview:
- Parametrised, pipelined radix-2 DIT butterfly stage for an N-point complex FFT/IFFT. Successor to the fixed 8-point, stage-2 butterfly blocks.
- One instance per FFT stage, selected by STAGE. Instances are chained valid-to-valid: out_ready of stage s drives in_ready of stage s+1.
- Adds over the fixed blocks: general twiddles via a constant table, runtime FFT/IFFT mode, optional per-stage 1/2 scaling, saturation with a sticky overflow flag, and reset.

Parameters:
- DATA_W, 16: signed width of each real/imag sample.
- N, 8: points per vector. Power of two, 4..64.
- STAGE, 1: stage index 0..log2(N)-1. Half-span h = 2^STAGE.
- TW_W, 16: signed twiddle width. Q(TW_W-2) format, so 1.0 = 2^(TW_W-2).
- SCALE, 0: 1 = arithmetic shift right by 1 after add/sub; 0 = saturate, no shift.

Ports:
- clk  in  1  clock; all logic on the rising edge.
- rst  in  1  asynchronous, active-high reset.
- in_ready  in  1  input vector valid this cycle.
- inverse  in  1  0 = forward (W), 1 = inverse (conj W). Sampled with in_ready.
- din_real  in  N*DATA_W  element i at bits [i*DATA_W +: DATA_W], signed.
- din_imag  in  N*DATA_W  same packing as din_real.
- dout_real  out  N*DATA_W  registered result, same packing.
- dout_imag  out  N*DATA_W  registered result, same packing.
- out_ready  out  1  dout valid, asserted for one cycle per accepted vector.
- ovf  out  1  sticky saturation flag (SCALE=0 only).
- ovf_clr  in  1  synchronous clear of ovf.

Behaviour:
- Pairing: for group g and k in 0..h-1:
  - a = x[g*2h+k], b = x[g*2h+k+h].
  - W = exp(-j*2*pi*k/(2h)); use conj(W) when inverse=1.
  - t = b*W; y[g*2h+k] = a+t; y[g*2h+k+h] = a-t.
- Twiddle encoding: round(cos*2^(TW_W-2)), round(-sin*2^(TW_W-2)), elaborated as constants.
- Trivial twiddles (W = 1, -j, or +j when inverse) bypass the multiplier and are exact.
- Multiply:
  - Full-precision 4-multiply complex product.
  - Add 2^(TW_W-3), then arithmetic shift right by TW_W-2 (round half up).
  - Result kept at DATA_W+1 bits.
- Add/sub at DATA_W+2 bits, then:
  - SCALE=1: arithmetic shift right by 1, then saturate.
  - SCALE=0: saturate to [-2^(DATA_W-1), 2^(DATA_W-1)-1].
- ovf: set on any saturation of any output component.
- Pipeline, fully pipelined, one vector accepted per cycle, no stall:
  - P1: register the twiddle products, a, and the valid bit.
  - P2: register the sums into dout and the valid bit into out_ready.
  - Latency is exactly 2 cycles: in_ready at edge n gives out_ready high in cycle n+2.
- Output ordering is preserved. Input gaps produce identical output gaps.
- dout holds its last value while out_ready is low; it loads only when the P2 valid bit is set.
- inverse travels with its data. Toggling it between consecutive vectors affects only the vector it accompanies.
- Reset: dout_real, dout_imag, out_ready, ovf and all pipeline valid bits go to 0 immediately.
  - In-flight vectors are discarded.
  - After release, no out_ready until a new in_ready plus 2 cycles.
- ovf_clr in the same cycle as a new saturation: set wins, ovf = 1.
- Illegal parameters (N not a power of two, STAGE out of range) cause an elaboration-time error.

Decomposition:
- define.v (shared) holds:
  - `funEnable / `funDisable.
  - A twiddle constant function tw_re(k, m, TW_W) / tw_im(k, m, TW_W).
  - The Q-format one constant.
- Sub-module bf2_core: one complex butterfly.
  - Parameters DATA_W, TW_W, SCALE, plus a trivial-twiddle select.
  - Contains the P1/P2 datapath registers and a saturation flag output.
  - butterfly_stage instantiates N/2 of them via generate, plus the valid pipeline and the ovf OR/sticky logic.

Test Plan:
1. Fixed-stage match. N=8, STAGE=1, SCALE=0, inverse=0, real=[100,200,...,800], imag=0.
   -> 2 cycles later: y0=(400,0), y2=(-200,0), y1=(200,-400), y3=(200,400), y4=(1200,0), y6=(-200,0), y5=(600,-800), y7=(600,800).
   out_ready high for exactly 1 cycle.
2. Inverse mode. Same stimulus with inverse=1 -> y1=(200,400), y3=(200,-400), y5=(600,800), y7=(600,-800); y0, y2, y4, y6 unchanged from test 1.
3. Non-trivial twiddle. STAGE=2, x1=0, x5=(16384,0), all others 0.
   -> y1=(11585,-11585), y5=(-11585,11585).
   With inverse=1: y1=(11585,11585).
4. Saturation and scaling. STAGE=0, x0=x1=(32767,-32768).
   - SCALE=0: y0=(32767,-32768), y1=(0,0), ovf=1.
   - Pulse ovf_clr: ovf=0.
   - Pulse ovf_clr in the same cycle as a new saturating output: ovf stays 1.
   - SCALE=1: y0=(32767,-32768), ovf stays 0.
5. Throughput. in_ready high for 3 consecutive cycles with vectors A, B, C, then low 1 cycle, then D.
   -> out_ready pattern 1,1,1,0,1 starting 2 cycles after A. Outputs in order A, B, C, D; inverse honoured per vector.
6. Reset mid-flight. Assert rst one cycle after in_ready.
   -> dout=0, out_ready=0, ovf=0 immediately. No out_ready in the 3 cycles after release without a new input.
